// File: rtl/valid_ready_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready downstream port among NUM_REQ
// requesters; each grant lasts until MAX_BURST beats are sent or the requester drops valid.
module valid_ready_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ*DATA_W-1:0]   i_req_data,
  input  logic [NUM_REQ-1:0]          i_req_valid,
  output logic [NUM_REQ-1:0]          o_req_ready,
  output logic [DATA_W-1:0]           o_m_data,
  output logic                        o_m_valid,
  input  logic                        i_m_ready,
  output logic [NUM_REQ-1:0]          o_grant,
  output logic [$clog2(NUM_REQ)-1:0]  o_grant_id,
  output logic                        o_busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   ptr, ptr_next;
  logic [CNT_W-1:0]   beat_cnt, beat_cnt_next;
  logic [IDX_W-1:0]   grant_id_next;
  logic [NUM_REQ-1:0] grant_next;

  logic               in_grant;
  logic               slot_free;
  logic               accept;
  logic               release_grant;
  logic [DATA_W-1:0]  sel_data;

  int                 rr_idx;
  logic [IDX_W-1:0]   rr_cand;
  logic [IDX_W-1:0]   rr_sel;
  logic               rr_found;

  assign in_grant  = (state == GRANT);
  assign o_busy    = in_grant;
  assign slot_free = !o_m_valid || i_m_ready;
  assign sel_data  = i_req_data[int'(o_grant_id)*DATA_W +: DATA_W];
  assign accept    = in_grant && i_req_valid[o_grant_id] && slot_free;

  // Scan ptr, ptr+1, ... modulo NUM_REQ and keep the first valid requester.
  always_comb begin
    rr_idx   = 0;
    rr_cand  = '0;
    rr_sel   = '0;
    rr_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rr_idx = int'(ptr) + i;
      if (rr_idx >= NUM_REQ) rr_idx = rr_idx - NUM_REQ;
      rr_cand = IDX_W'(rr_idx);
      if (!rr_found && i_req_valid[rr_cand]) begin
        rr_found = 1'b1;
        rr_sel   = rr_cand;
      end
    end
  end

  always_comb begin
    o_req_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      o_req_ready[k] = in_grant && (o_grant_id == IDX_W'(k)) && slot_free;
    end
  end

  always_comb begin
    state_next    = state;
    ptr_next      = ptr;
    beat_cnt_next = beat_cnt;
    grant_id_next = o_grant_id;
    grant_next    = o_grant;
    release_grant = 1'b0;
    case (state)
      IDLE: begin
        if (rr_found) begin
          state_next    = GRANT;
          grant_id_next = rr_sel;
          grant_next    = NUM_REQ'(1) << rr_sel;
          beat_cnt_next = '0;
        end
      end
      GRANT: begin
        if (accept) begin
          if (beat_cnt == CNT_W'(MAX_BURST - 1)) release_grant = 1'b1;
          else beat_cnt_next = beat_cnt + 1'b1;
        end else if (!i_req_valid[o_grant_id]) begin
          release_grant = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    // Releasing hands priority to the requester just after the one that was served.
    if (release_grant) begin
      state_next    = IDLE;
      ptr_next      = (o_grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : o_grant_id + 1'b1;
      grant_id_next = '0;
      grant_next    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      beat_cnt   <= '0;
      o_grant_id <= '0;
      o_grant    <= '0;
    end else begin
      state      <= state_next;
      ptr        <= ptr_next;
      beat_cnt   <= beat_cnt_next;
      o_grant_id <= grant_id_next;
      o_grant    <= grant_next;
    end
  end

  // Output slice: a new beat loads only when the slot is empty or draining this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_m_valid <= 1'b0;
      o_m_data  <= '0;
    end else if (accept) begin
      o_m_valid <= 1'b1;
      o_m_data  <= sel_data;
    end else if (i_m_ready) begin
      o_m_valid <= 1'b0;
    end
  end

endmodule
